arb_rr_seq: RTL and testbench

- Sequential, parametrised arbiter: N requesters, one registered one-hot grant, owned until release.
- Successor to the combinational request decoder; adds a fixed-priority / round-robin mode switch, grant locking, a hold-time limit, and an index output.
- Sits between requester masters and a shared resource (bus / memory port); grant drives the downstream mux select.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/arb_pick.sv | 16 +
 rtl/arb_rr_seq.sv | 128 ++++++++++++
 tb/tb_arb_rr_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the sequential round-robin / fixed-priority arbiter.
// The index helper is sized for the largest supported requester count.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int MAX_N      = 64;

  // Binary index of a one-hot (or all-zero) vector; OR-accumulation is exact for one-hot input.
  function automatic logic [5:0] onehot2idx(input logic [MAX_N-1:0] oh);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational lowest-set-bit picker: isolates the lowest set bit of vec as a one-hot.
module arb_pick
  import arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] onehot,
  output logic         valid
);

  // Two's-complement trick: vec & -vec keeps only the lowest set bit.
  assign onehot = vec & (~vec + N'(1));
  assign valid  = |vec;

endmodule

// File: rtl/arb_rr_seq.sv
// Sequential N-way arbiter with a registered one-hot grant owned until release, withdraw
// or hold-time expiry, followed by a mandatory one-cycle turnaround bubble.
module arb_rr_seq
  import arb_pkg::*;
#(
  parameter int N        = 32,
  parameter int MODE     = 1,
  parameter int HOLD_MAX = 16,
  parameter int IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          rel,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx,
  output logic          expired
);

  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  arb_state_e    state;
  logic [HW-1:0] hold_cnt;
  logic [N-1:0]  win_oh;
  logic [IW-1:0] win_idx;
  logic          req_any;
  logic          owner_req;
  logic          hold_hit;
  logic          own_exit;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [IW-1:0] ptr;
      logic [N-1:0]  mask;
      logic [N-1:0]  m_oh;
      logic [N-1:0]  u_oh;
      logic          m_vld;
      logic          u_vld;

      always_comb begin
        for (int i = 0; i < N; i++) mask[i] = (i >= int'(ptr));
      end

      arb_pick #(.N(N)) u_masked (.vec(req & mask), .onehot(m_oh), .valid(m_vld));
      arb_pick #(.N(N)) u_full   (.vec(req),        .onehot(u_oh), .valid(u_vld));

      // Search upward from ptr first; fall back to the wrapped (unmasked) pick.
      assign win_oh  = m_vld ? m_oh : u_oh;
      assign req_any = u_vld;

      // NOTE: sequential state is updated with non-blocking assignments only, so every
      // register samples the pre-edge values regardless of block ordering.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr <= '0;
        end else if (state == OWN && own_exit) begin
          ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
      end
    end else begin : g_fixed
      logic [N-1:0] rev;
      logic [N-1:0] rev_oh;
      logic         vld;

      // Highest index wins: pick the lowest bit of the bit-reversed request, reverse back.
      always_comb begin
        for (int i = 0; i < N; i++) rev[i] = req[N-1-i];
      end

      arb_pick #(.N(N)) u_rev (.vec(rev), .onehot(rev_oh), .valid(vld));

      always_comb begin
        for (int i = 0; i < N; i++) win_oh[i] = rev_oh[N-1-i];
      end

      assign req_any = vld;
    end
  endgenerate

  assign win_idx   = IW'(onehot2idx(64'(win_oh)));
  assign owner_req = |(req & grant);
  assign hold_hit  = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST);
  assign own_exit  = rel || !owner_req || hold_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      expired     <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      expired <= 1'b0;
      unique case (state)
        IDLE, GAP: begin
          if (req_any) begin
            state       <= OWN;
            grant       <= win_oh;
            grant_valid <= 1'b1;
            grant_idx   <= win_idx;
            hold_cnt    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        OWN: begin
          if (own_exit) begin
            state       <= GAP;
            grant       <= '0;
            grant_valid <= 1'b0;
            // Only a revoke caused purely by the hold limit is reported.
            expired     <= hold_hit && !rel && owner_req;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant) && (grant_valid == (|grant)));

endmodule

// File: tb/tb_arb_rr_seq.sv
// Self-checking bench for arb_rr_seq: directed scenarios on several configurations plus
// randomized traffic checked against a cycle-level behavioural model.
module tb_arb_rr_seq;

  localparam int ND   = 5;
  localparam int D_RR = 0;  // N=4, round robin, unlimited hold
  localparam int D_FP = 1;  // N=4, fixed priority, unlimited hold
  localparam int D_HO = 2;  // N=4, round robin, HOLD_MAX=3
  localparam int D_N5 = 3;  // N=5, round robin, unlimited hold
  localparam int D_H1 = 4;  // N=3, fixed priority, HOLD_MAX=1
  localparam int DN    [ND] = '{4, 4, 4, 5, 3};
  localparam int DMODE [ND] = '{1, 0, 1, 1, 0};
  localparam int DHOLD [ND] = '{0, 0, 3, 0, 1};

  typedef struct packed {
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [7:0] idx;
    logic       exp;
  } step_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] req_v [ND];
  logic        rel_v [ND];
  logic [63:0] gnt_v [ND];
  logic        vld_v [ND];
  logic [7:0]  idx_v [ND];
  logic        exp_v [ND];

  logic [3:0] rr_g, fp_g, ho_g;
  logic [4:0] n5_g;
  logic [2:0] h1_g;
  logic [1:0] rr_i, fp_i, ho_i, h1_i;
  logic [2:0] n5_i;
  logic       rr_v, fp_v, ho_v, n5_v, h1_v;
  logic       rr_e, fp_e, ho_e, n5_e, h1_e;

  int n_cmp = 0;
  int n_bad = 0;

  int m_owner [ND];
  int m_held  [ND];
  int m_ptr   [ND];
  int m_idx   [ND];
  bit m_exp   [ND];

  arb_rr_seq #(.N(4), .MODE(1), .HOLD_MAX(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req_v[D_RR][3:0]), .rel(rel_v[D_RR]),
    .grant(rr_g), .grant_valid(rr_v), .grant_idx(rr_i), .expired(rr_e));
  arb_rr_seq #(.N(4), .MODE(0), .HOLD_MAX(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req(req_v[D_FP][3:0]), .rel(rel_v[D_FP]),
    .grant(fp_g), .grant_valid(fp_v), .grant_idx(fp_i), .expired(fp_e));
  arb_rr_seq #(.N(4), .MODE(1), .HOLD_MAX(3)) u_ho (
    .clk(clk), .rst_n(rst_n), .req(req_v[D_HO][3:0]), .rel(rel_v[D_HO]),
    .grant(ho_g), .grant_valid(ho_v), .grant_idx(ho_i), .expired(ho_e));
  arb_rr_seq #(.N(5), .MODE(1), .HOLD_MAX(0)) u_n5 (
    .clk(clk), .rst_n(rst_n), .req(req_v[D_N5][4:0]), .rel(rel_v[D_N5]),
    .grant(n5_g), .grant_valid(n5_v), .grant_idx(n5_i), .expired(n5_e));
  arb_rr_seq #(.N(3), .MODE(0), .HOLD_MAX(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .req(req_v[D_H1][2:0]), .rel(rel_v[D_H1]),
    .grant(h1_g), .grant_valid(h1_v), .grant_idx(h1_i), .expired(h1_e));

  always_comb begin
    gnt_v[D_RR] = 64'(rr_g); vld_v[D_RR] = rr_v; idx_v[D_RR] = 8'(rr_i); exp_v[D_RR] = rr_e;
    gnt_v[D_FP] = 64'(fp_g); vld_v[D_FP] = fp_v; idx_v[D_FP] = 8'(fp_i); exp_v[D_FP] = fp_e;
    gnt_v[D_HO] = 64'(ho_g); vld_v[D_HO] = ho_v; idx_v[D_HO] = 8'(ho_i); exp_v[D_HO] = ho_e;
    gnt_v[D_N5] = 64'(n5_g); vld_v[D_N5] = n5_v; idx_v[D_N5] = 8'(n5_i); exp_v[D_N5] = n5_e;
    gnt_v[D_H1] = 64'(h1_g); vld_v[D_H1] = h1_v; idx_v[D_H1] = 8'(h1_i); exp_v[D_H1] = h1_e;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: owner number (-1 = none) and cycles owned, advanced once per clock edge.
  function automatic int model_pick(int d, logic [63:0] r);
    if (DMODE[d] == 0) begin
      for (int i = DN[d] - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < DN[d]; k++) begin
        int j;
        j = (m_ptr[d] + k) % DN[d];
        if (r[j]) return j;
      end
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < ND; d++) begin
      m_owner[d] = -1; m_held[d] = 0; m_ptr[d] = 0; m_idx[d] = 0; m_exp[d] = 1'b0;
    end
  endfunction

  function automatic void model_step(int d, logic [63:0] r, logic rl);
    bit still, hit;
    m_exp[d] = 1'b0;
    if (m_owner[d] >= 0) begin
      still = r[m_owner[d]];
      hit   = (DHOLD[d] != 0) && (m_held[d] == DHOLD[d]);
      if (rl || !still || hit) begin
        m_exp[d] = hit && !rl && still;
        if (DMODE[d] == 1) m_ptr[d] = (m_owner[d] + 1) % DN[d];
        m_owner[d] = -1;
      end else begin
        m_held[d]++;
      end
    end else if (r != 64'd0) begin
      m_owner[d] = model_pick(d, r);
      m_held[d]  = 1;
      m_idx[d]   = m_owner[d];
    end
  endfunction

  task automatic test_reset();
    for (int d = 0; d < ND; d++) begin
      n_cmp++;
      if ({gnt_v[d], vld_v[d], idx_v[d], exp_v[d]} !== 74'd0) begin
        n_bad++;
        $display("FAIL reset dut%0d: got grant=%0h valid=%b idx=%0d expired=%b, want all zero",
                 d, gnt_v[d], vld_v[d], idx_v[d], exp_v[d]);
      end
    end
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < ND; d++) begin
      n_cmp++;
      if ({gnt_v[d], vld_v[d], idx_v[d], exp_v[d]} !== 74'd0) begin
        n_bad++;
        $display("FAIL idle_after_reset dut%0d: got grant=%0h valid=%b idx=%0d expired=%b, want all zero",
                 d, gnt_v[d], vld_v[d], idx_v[d], exp_v[d]);
      end
    end
  endtask

  task automatic test_round_robin();
    step_t s [11];
    s = '{'{8'hF, 1'b0, 8'h1, 8'd0, 1'b0}, '{8'hF, 1'b1, 8'h0, 8'd0, 1'b0},
          '{8'hF, 1'b0, 8'h2, 8'd1, 1'b0}, '{8'hF, 1'b1, 8'h0, 8'd1, 1'b0},
          '{8'hF, 1'b0, 8'h4, 8'd2, 1'b0}, '{8'hF, 1'b1, 8'h0, 8'd2, 1'b0},
          '{8'hF, 1'b0, 8'h8, 8'd3, 1'b0}, '{8'hF, 1'b1, 8'h0, 8'd3, 1'b0},
          '{8'hF, 1'b0, 8'h1, 8'd0, 1'b0}, '{8'h0, 1'b1, 8'h0, 8'd0, 1'b0},
          '{8'h0, 1'b0, 8'h0, 8'd0, 1'b0}};
    for (int i = 0; i < 11; i++) begin
      req_v[D_RR] = 64'(s[i].req); rel_v[D_RR] = s[i].rel;
      tick();
      n_cmp++;
      if ({gnt_v[D_RR], vld_v[D_RR], idx_v[D_RR], exp_v[D_RR]} !==
          {64'(s[i].gnt), |s[i].gnt, s[i].idx, s[i].exp}) begin
        n_bad++;
        $display("FAIL round_robin step %0d: got grant=%b valid=%b idx=%0d exp=%b, want grant=%b valid=%b idx=%0d exp=%b",
                 i, gnt_v[D_RR][3:0], vld_v[D_RR], idx_v[D_RR], exp_v[D_RR],
                 s[i].gnt[3:0], |s[i].gnt, s[i].idx, s[i].exp);
      end
    end
  endtask

  task automatic test_fixed_priority();
    step_t s [7];
    s = '{'{8'h5, 1'b0, 8'h4, 8'd2, 1'b0}, '{8'hD, 1'b0, 8'h4, 8'd2, 1'b0},
          '{8'hD, 1'b0, 8'h4, 8'd2, 1'b0}, '{8'hD, 1'b1, 8'h0, 8'd2, 1'b0},
          '{8'hD, 1'b0, 8'h8, 8'd3, 1'b0}, '{8'h0, 1'b1, 8'h0, 8'd3, 1'b0},
          '{8'h0, 1'b0, 8'h0, 8'd3, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      req_v[D_FP] = 64'(s[i].req); rel_v[D_FP] = s[i].rel;
      tick();
      n_cmp++;
      if ({gnt_v[D_FP], vld_v[D_FP], idx_v[D_FP], exp_v[D_FP]} !==
          {64'(s[i].gnt), |s[i].gnt, s[i].idx, s[i].exp}) begin
        n_bad++;
        $display("FAIL fixed_priority step %0d: got grant=%b valid=%b idx=%0d exp=%b, want grant=%b valid=%b idx=%0d exp=%b",
                 i, gnt_v[D_FP][3:0], vld_v[D_FP], idx_v[D_FP], exp_v[D_FP],
                 s[i].gnt[3:0], |s[i].gnt, s[i].idx, s[i].exp);
      end
    end
  endtask

  task automatic test_hold_expire();
    step_t s [7];
    s = '{'{8'h2, 1'b0, 8'h2, 8'd1, 1'b0}, '{8'h2, 1'b0, 8'h2, 8'd1, 1'b0},
          '{8'h2, 1'b0, 8'h2, 8'd1, 1'b0}, '{8'h2, 1'b0, 8'h0, 8'd1, 1'b1},
          '{8'h2, 1'b0, 8'h2, 8'd1, 1'b0}, '{8'h0, 1'b0, 8'h0, 8'd1, 1'b0},
          '{8'h0, 1'b0, 8'h0, 8'd1, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      req_v[D_HO] = 64'(s[i].req); rel_v[D_HO] = s[i].rel;
      tick();
      n_cmp++;
      if ({gnt_v[D_HO], vld_v[D_HO], idx_v[D_HO], exp_v[D_HO]} !==
          {64'(s[i].gnt), |s[i].gnt, s[i].idx, s[i].exp}) begin
        n_bad++;
        $display("FAIL hold_expire step %0d: got grant=%b valid=%b idx=%0d exp=%b, want grant=%b valid=%b idx=%0d exp=%b",
                 i, gnt_v[D_HO][3:0], vld_v[D_HO], idx_v[D_HO], exp_v[D_HO],
                 s[i].gnt[3:0], |s[i].gnt, s[i].idx, s[i].exp);
      end
    end
  endtask

  task automatic test_hold_release();
    // Limit reached together with rel, then together with a withdraw: neither is an expiry.
    step_t s [9];
    s = '{'{8'h2, 1'b0, 8'h2, 8'd1, 1'b0}, '{8'h2, 1'b0, 8'h2, 8'd1, 1'b0},
          '{8'h2, 1'b0, 8'h2, 8'd1, 1'b0}, '{8'h2, 1'b1, 8'h0, 8'd1, 1'b0},
          '{8'h2, 1'b0, 8'h2, 8'd1, 1'b0}, '{8'h2, 1'b0, 8'h2, 8'd1, 1'b0},
          '{8'h2, 1'b0, 8'h2, 8'd1, 1'b0}, '{8'h0, 1'b0, 8'h0, 8'd1, 1'b0},
          '{8'h0, 1'b0, 8'h0, 8'd1, 1'b0}};
    for (int i = 0; i < 9; i++) begin
      req_v[D_HO] = 64'(s[i].req); rel_v[D_HO] = s[i].rel;
      tick();
      n_cmp++;
      if ({gnt_v[D_HO], vld_v[D_HO], idx_v[D_HO], exp_v[D_HO]} !==
          {64'(s[i].gnt), |s[i].gnt, s[i].idx, s[i].exp}) begin
        n_bad++;
        $display("FAIL hold_release step %0d: got grant=%b valid=%b idx=%0d exp=%b, want grant=%b valid=%b idx=%0d exp=%b",
                 i, gnt_v[D_HO][3:0], vld_v[D_HO], idx_v[D_HO], exp_v[D_HO],
                 s[i].gnt[3:0], |s[i].gnt, s[i].idx, s[i].exp);
      end
    end
  endtask

  task automatic test_withdraw();
    step_t s [7];
    s = '{'{8'h4, 1'b0, 8'h4, 8'd2, 1'b0}, '{8'h8, 1'b0, 8'h0, 8'd2, 1'b0},
          '{8'h8, 1'b0, 8'h8, 8'd3, 1'b0}, '{8'hF, 1'b1, 8'h0, 8'd3, 1'b0},
          '{8'hF, 1'b0, 8'h1, 8'd0, 1'b0}, '{8'h0, 1'b1, 8'h0, 8'd0, 1'b0},
          '{8'h0, 1'b0, 8'h0, 8'd0, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      req_v[D_RR] = 64'(s[i].req); rel_v[D_RR] = s[i].rel;
      tick();
      n_cmp++;
      if ({gnt_v[D_RR], vld_v[D_RR], idx_v[D_RR], exp_v[D_RR]} !==
          {64'(s[i].gnt), |s[i].gnt, s[i].idx, s[i].exp}) begin
        n_bad++;
        $display("FAIL withdraw step %0d: got grant=%b valid=%b idx=%0d exp=%b, want grant=%b valid=%b idx=%0d exp=%b",
                 i, gnt_v[D_RR][3:0], vld_v[D_RR], idx_v[D_RR], exp_v[D_RR],
                 s[i].gnt[3:0], |s[i].gnt, s[i].idx, s[i].exp);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    step_t s [3];
    req_v[D_RR] = 64'hF; rel_v[D_RR] = 1'b0;
    tick();
    n_cmp++;
    if ({gnt_v[D_RR], idx_v[D_RR]} !== {64'h2, 8'd1}) begin
      n_bad++;
      $display("FAIL pre_reset_grant: got grant=%b idx=%0d, want grant=0010 idx=1",
               gnt_v[D_RR][3:0], idx_v[D_RR]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt_v[D_RR], vld_v[D_RR], idx_v[D_RR], exp_v[D_RR]} !== 74'd0) begin
      n_bad++;
      $display("FAIL async_reset: got grant=%b valid=%b idx=%0d exp=%b, want all zero",
               gnt_v[D_RR][3:0], vld_v[D_RR], idx_v[D_RR], exp_v[D_RR]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // The search pointer must restart at 0, so requester 0 wins over the pre-reset successor.
    s = '{'{8'hF, 1'b0, 8'h1, 8'd0, 1'b0}, '{8'h0, 1'b1, 8'h0, 8'd0, 1'b0},
          '{8'h0, 1'b0, 8'h0, 8'd0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      req_v[D_RR] = 64'(s[i].req); rel_v[D_RR] = s[i].rel;
      tick();
      n_cmp++;
      if ({gnt_v[D_RR], vld_v[D_RR], idx_v[D_RR], exp_v[D_RR]} !==
          {64'(s[i].gnt), |s[i].gnt, s[i].idx, s[i].exp}) begin
        n_bad++;
        $display("FAIL post_reset step %0d: got grant=%b valid=%b idx=%0d exp=%b, want grant=%b valid=%b idx=%0d exp=%b",
                 i, gnt_v[D_RR][3:0], vld_v[D_RR], idx_v[D_RR], exp_v[D_RR],
                 s[i].gnt[3:0], |s[i].gnt, s[i].idx, s[i].exp);
      end
    end
  endtask

  task automatic test_n5_wrap();
    step_t s [9];
    s = '{'{8'h11, 1'b0, 8'h01, 8'd0, 1'b0}, '{8'h11, 1'b1, 8'h00, 8'd0, 1'b0},
          '{8'h11, 1'b0, 8'h10, 8'd4, 1'b0}, '{8'h11, 1'b1, 8'h00, 8'd4, 1'b0},
          '{8'h11, 1'b0, 8'h01, 8'd0, 1'b0}, '{8'h11, 1'b1, 8'h00, 8'd0, 1'b0},
          '{8'h11, 1'b0, 8'h10, 8'd4, 1'b0}, '{8'h00, 1'b1, 8'h00, 8'd4, 1'b0},
          '{8'h00, 1'b0, 8'h00, 8'd4, 1'b0}};
    for (int i = 0; i < 9; i++) begin
      req_v[D_N5] = 64'(s[i].req); rel_v[D_N5] = s[i].rel;
      tick();
      n_cmp++;
      if ({gnt_v[D_N5], vld_v[D_N5], idx_v[D_N5], exp_v[D_N5]} !==
          {64'(s[i].gnt), |s[i].gnt, s[i].idx, s[i].exp}) begin
        n_bad++;
        $display("FAIL n5_wrap step %0d: got grant=%b valid=%b idx=%0d exp=%b, want grant=%b valid=%b idx=%0d exp=%b",
                 i, gnt_v[D_N5][4:0], vld_v[D_N5], idx_v[D_N5], exp_v[D_N5],
                 s[i].gnt[4:0], |s[i].gnt, s[i].idx, s[i].exp);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] r [ND];
    logic [63:0] want_g;
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      req_v[d] = '0; rel_v[d] = 1'b0; r[d] = '0;
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < ND; d++) begin
        for (int b = 0; b < DN[d]; b++) begin
          if ($urandom_range(3) == 0) r[d][b] = ~r[d][b];
        end
        req_v[d] = r[d];
        rel_v[d] = ($urandom_range(4) == 0);
      end
      @(posedge clk);
      for (int d = 0; d < ND; d++) model_step(d, req_v[d], rel_v[d]);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        want_g = (m_owner[d] >= 0) ? (64'd1 << m_owner[d]) : 64'd0;
        n_cmp++;
        if ({gnt_v[d], vld_v[d], idx_v[d], exp_v[d]} !==
            {want_g, m_owner[d] >= 0, 8'(m_idx[d]), m_exp[d]}) begin
          n_bad++;
          $display("FAIL random cycle %0d dut%0d: got grant=%0h valid=%b idx=%0d exp=%b, want grant=%0h valid=%b idx=%0d exp=%b",
                   c, d, gnt_v[d], vld_v[d], idx_v[d], exp_v[d],
                   want_g, m_owner[d] >= 0, m_idx[d], m_exp[d]);
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      req_v[d] = '0; rel_v[d] = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      req_v[d] = '0;
      rel_v[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_hold_expire();
    test_hold_release();
    test_withdraw();
    test_reset_mid_grant();
    test_n5_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
